// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle RV64 datapath and a 64-bit data memory.
// Sub-doubleword stores use read-modify-write; sd writes directly.
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [63:0] rdata,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_next;

    logic [63:0] base_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;
    logic [63:0] rdata_q;
    logic [63:0] merge_q;

    logic        accept;
    logic        bad;
    logic        is_sd;
    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] ext;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] merged;

    assign accept = req && (state == S_IDLE);
    assign is_sd  = we && (funct3 == 3'b011);

    // Alignment and legality of the incoming request
    always_comb begin
        bad = 1'b1;
        case (funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = |addr[1:0];
            3'b011:  bad = |addr[2:0];
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            3'b110:  bad = we | (|addr[1:0]);
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad)
                        state_next = S_DONE;
                    else if (is_sd)
                        state_next = S_WRITE;
                    else
                        state_next = S_READ;
                end
            end
            S_READ:  state_next = S_WAIT;
            S_WAIT:  state_next = we_q ? S_WRITE : S_DONE;
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign shamt = {off_q, 3'b000};
    assign lane  = mem_rdata >> shamt;

    always_comb begin
        ext       = lane;
        size_mask = '1;
        case (f3_q[1:0])
            2'b00: begin
                ext       = f3_q[2] ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
                size_mask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                ext       = f3_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                ext       = f3_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                ext       = lane;
                size_mask = '1;
            end
        endcase
    end

    assign lane_mask = size_mask << shamt;
    assign lane_data = (wdata_q & size_mask) << shamt;
    assign merged    = (mem_rdata & ~lane_mask) | lane_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            base_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                base_q  <= {addr[63:3], 3'b000};
                off_q   <= addr[2:0];
                wdata_q <= wdata;
                f3_q    <= funct3;
                we_q    <= we;
                err_q   <= bad;
                // sd skips the read phase, so its data goes straight to the write buffer
                if (is_sd && !bad)
                    merge_q <= wdata;
            end
            if (state == S_WAIT) begin
                if (we_q)
                    merge_q <= merged;
                else
                    rdata_q <= ext;
            end
        end
    end

    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_wr    = (state == S_WRITE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_raddr = base_q;
    assign mem_waddr = base_q;
    assign mem_wdata = merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner sequences and randomized
// operations against a byte-array reference memory.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    mem_access_unit dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read data memory seen by the DUT
    logic [63:0] dmem [0:127];
    logic        init_we;
    logic [6:0]  init_idx;
    logic [63:0] init_val;

    always @(posedge clock) begin
        if (init_we)
            dmem[init_idx] <= init_val;
        else if (mem_wr)
            dmem[mem_waddr[9:3]] <= mem_wdata;
        mem_rdata <= dmem[mem_raddr[9:3]];
    end

    // Reference memory as plain bytes
    logic [7:0] rmem [0:1023];

    int checks;
    int failures;

    int          res_done_cyc;
    int          res_wr_cnt;
    int          res_wr_cyc;
    logic [63:0] res_wr_addr;
    logic [63:0] res_wr_data;
    logic        res_err;
    logic [63:0] res_rdata;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        int          exp_cyc;
        logic [63:0] exp_rdata;
        logic        exp_wr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs [18];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_dw(input int idx, input logic [63:0] val);
        init_we  = 1'b1;
        init_idx = idx[6:0];
        init_val = val;
        @(posedge clock);
        #1;
        init_we  = 1'b0;
        for (int b = 0; b < 8; b++)
            rmem[idx * 8 + b] = val[8 * b +: 8];
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [63:0] a);
        if (f3 == 3'b111) return 1'b1;
        if (w && f3[2]) return 1'b1;
        return (a % 64'(size_of(f3))) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        int          n;
        logic [63:0] v;
        n = size_of(f3);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | ({56'd0, rmem[int'(a[9:0]) + i]} << (8 * i));
        if (!f3[2] && n < 8 && v[8 * n - 1])
            v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    function automatic logic [63:0] ref_dword(input logic [63:0] a);
        logic [63:0] v;
        int          base;
        base = int'(a[9:3]) * 8;
        for (int b = 0; b < 8; b++)
            v[8 * b +: 8] = rmem[base + b];
        return v;
    endfunction

    // Issue one request from an idle point (#1 after a rising edge) and observe it to completion
    task automatic run_op(input logic op_we, input logic [2:0] op_f3,
                          input logic [63:0] op_addr, input logic [63:0] op_wdata);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_issue actual=%b required=1", ready);
        end
        req    = 1'b1;
        we     = op_we;
        funct3 = op_f3;
        addr   = op_addr;
        wdata  = op_wdata;
        @(posedge clock);
        #1;
        req    = 1'b0;
        we     = 1'($urandom);
        funct3 = 3'($urandom);
        addr   = {$urandom, $urandom};
        wdata  = {$urandom, $urandom};
        res_done_cyc = -1;
        res_wr_cnt   = 0;
        res_wr_cyc   = -1;
        res_wr_addr  = '0;
        res_wr_data  = '0;
        res_err      = 1'bx;
        res_rdata    = 'x;
        for (int c = 1; c <= 12; c++) begin
            if (mem_wr) begin
                res_wr_cnt++;
                res_wr_cyc  = c;
                res_wr_addr = mem_waddr;
                res_wr_data = mem_wdata;
            end
            if (done) begin
                res_done_cyc = c;
                res_err      = err;
                res_rdata    = rdata;
                break;
            end
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_op(input string tag, input logic x_err, input int x_cyc,
                            input logic [63:0] x_rdata, input logic x_wr, input int x_wr_cyc,
                            input logic [63:0] x_waddr, input logic [63:0] x_wdata);
        check64({tag, ".done_cycle"}, 64'(res_done_cyc), 64'(x_cyc));
        check64({tag, ".err"}, {63'd0, res_err}, {63'd0, x_err});
        check64({tag, ".rdata"}, res_rdata, x_rdata);
        check64({tag, ".wr_count"}, 64'(res_wr_cnt), x_wr ? 64'd1 : 64'd0);
        if (x_wr) begin
            check64({tag, ".wr_cycle"}, 64'(res_wr_cyc), 64'(x_wr_cyc));
            check64({tag, ".wr_addr"}, res_wr_addr, x_waddr);
            check64({tag, ".wr_data"}, res_wr_data, x_wdata);
        end
    endtask

    int          ready_seen [1:8];
    int          d1_cyc, d2_cyc, b2b_wr;
    logic [63:0] d1_rd, d2_rd;
    logic [63:0] exp_rd;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        funct3   = '0;
        addr     = '0;
        wdata    = '0;
        init_we  = 1'b0;
        init_idx = '0;
        init_val = '0;

        vecs[0]  = '{1'b0, 3'b000, 64'h107, 64'h0, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 3'b100, 64'h107, 64'h0, 1'b0, 3, 64'h0000_0000_0000_0088, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 3'b010, 64'h104, 64'h0, 1'b0, 3, 64'hFFFF_FFFF_8877_6655, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 3'b010, 64'h102, 64'h0, 1'b1, 1, 64'hFFFF_FFFF_8877_6655, 1'b0, 64'h0};
        vecs[4]  = '{1'b1, 3'b001, 64'h102, 64'hABCD, 1'b0, 4, 64'hFFFF_FFFF_8877_6655, 1'b1, 64'h8877_6655_ABCD_2211};
        vecs[5]  = '{1'b0, 3'b011, 64'h100, 64'h0, 1'b0, 3, 64'h8877_6655_ABCD_2211, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 64'h8877_6655_ABCD_2211, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[7]  = '{1'b0, 3'b011, 64'h108, 64'h0, 1'b0, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, 3'b100, 64'h100, 64'h5A, 1'b1, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 3'b011, 64'h100, 64'h0, 1'b0, 3, 64'h8877_6655_ABCD_2211, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 3'b101, 64'h106, 64'h0, 1'b0, 3, 64'h0000_0000_0000_8877, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 3'b001, 64'h106, 64'h0, 1'b0, 3, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 64'h0};
        vecs[12] = '{1'b0, 3'b110, 64'h104, 64'h0, 1'b0, 3, 64'h0000_0000_8877_6655, 1'b0, 64'h0};
        vecs[13] = '{1'b0, 3'b111, 64'h100, 64'h0, 1'b1, 1, 64'h0000_0000_8877_6655, 1'b0, 64'h0};
        vecs[14] = '{1'b1, 3'b010, 64'h10C, 64'hFFFF_FFFF_1122_3344, 1'b0, 4, 64'h0000_0000_8877_6655, 1'b1, 64'h1122_3344_89AB_CDEF};
        vecs[15] = '{1'b0, 3'b011, 64'h108, 64'h0, 1'b0, 3, 64'h1122_3344_89AB_CDEF, 1'b0, 64'h0};
        vecs[16] = '{1'b0, 3'b001, 64'h101, 64'h0, 1'b1, 1, 64'h1122_3344_89AB_CDEF, 1'b0, 64'h0};
        vecs[17] = '{1'b1, 3'b011, 64'h104, 64'h77, 1'b1, 1, 64'h1122_3344_89AB_CDEF, 1'b0, 64'h0};

        for (int d = 0; d < 128; d++)
            set_dw(d, 64'd0);
        set_dw(32, 64'h8877_6655_4433_2211);

        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check64("reset.ready", {63'd0, ready}, 64'd1);
        check64("reset.done", {63'd0, done}, 64'd0);
        check64("reset.err", {63'd0, err}, 64'd0);
        check64("reset.rdata", rdata, 64'd0);
        check64("reset.mem_wr", {63'd0, mem_wr}, 64'd0);
        check64("reset.mem_raddr", mem_raddr, 64'd0);
        check64("reset.mem_waddr", mem_waddr, 64'd0);
        check64("reset.mem_wdata", mem_wdata, 64'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            check_op($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_cyc, vecs[i].exp_rdata,
                     vecs[i].exp_wr, (vecs[i].f3 == 3'b011) ? 1 : 3,
                     {vecs[i].addr[63:3], 3'b000}, vecs[i].exp_wdata);
        end

        // req held high: busy-time input changes ignored, second load taken right after DONE
        req    = 1'b1;
        we     = 1'b0;
        funct3 = 3'b011;
        addr   = 64'h100;
        wdata  = '0;
        @(posedge clock);
        #1;
        d1_cyc = -1;
        d2_cyc = -1;
        d1_rd  = '0;
        d2_rd  = '0;
        b2b_wr = 0;
        for (int c = 1; c <= 8; c++) begin
            ready_seen[c] = int'(ready);
            if (mem_wr) b2b_wr++;
            if (done && d1_cyc < 0) begin
                d1_cyc = c;
                d1_rd  = rdata;
            end else if (done) begin
                d2_cyc = c;
                d2_rd  = rdata;
            end
            if (c <= 2) begin
                we     = 1'b1;
                funct3 = 3'b000;
                addr   = 64'h100;
                wdata  = 64'hFF;
            end else if (c == 3) begin
                we     = 1'b0;
                funct3 = 3'b100;
                addr   = 64'h101;
            end else if (c == 5) begin
                req = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        check64("b2b.first_done_cycle", 64'(d1_cyc), 64'd3);
        check64("b2b.first_rdata", d1_rd, 64'h8877_6655_ABCD_2211);
        check64("b2b.ready_in_done", 64'(ready_seen[3]), 64'd0);
        check64("b2b.ready_after_done", 64'(ready_seen[4]), 64'd1);
        check64("b2b.ready_busy2", 64'(ready_seen[5]), 64'd0);
        check64("b2b.second_done_cycle", 64'(d2_cyc), 64'd7);
        check64("b2b.second_rdata", d2_rd, 64'h0000_0000_0000_0022);
        check64("b2b.wr_count", 64'(b2b_wr), 64'd0);
        check64("b2b.mem", dmem[32], 64'h8877_6655_ABCD_2211);

        // Reset while an sb is in its write cycle
        req    = 1'b1;
        we     = 1'b1;
        funct3 = 3'b000;
        addr   = 64'h100;
        wdata  = 64'h5A;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check64("rst_wr.mem_wr_before", {63'd0, mem_wr}, 64'd1);
        reset = 1'b1;
        #1;
        check64("rst_wr.mem_wr_cut", {63'd0, mem_wr}, 64'd0);
        check64("rst_wr.ready", {63'd0, ready}, 64'd1);
        check64("rst_wr.done", {63'd0, done}, 64'd0);
        check64("rst_wr.rdata", rdata, 64'd0);
        check64("rst_wr.mem_wdata", mem_wdata, 64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check64("rst_wr.mem_unchanged", dmem[32], 64'h8877_6655_ABCD_2211);

        // Randomized operations against the byte-level reference
        for (int d = 0; d < 128; d++)
            set_dw(d, {$urandom, $urandom});
        exp_rd = '0;
        for (int n = 0; n < 300; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [63:0] r_a;
            logic [63:0] r_wd;
            logic        e;
            int          cyc;
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0)
                r_a = r_a & ~64'(size_of(r_f3) - 1);
            r_wd = {$urandom, $urandom};
            e    = ref_err(r_we, r_f3, r_a);
            if (e)
                cyc = 1;
            else if (!r_we)
                cyc = 3;
            else if (r_f3 == 3'b011)
                cyc = 2;
            else
                cyc = 4;
            if (!e && !r_we)
                exp_rd = ref_load(r_f3, r_a);
            if (!e && r_we)
                for (int i = 0; i < size_of(r_f3); i++)
                    rmem[int'(r_a[9:0]) + i] = r_wd[8 * i +: 8];
            run_op(r_we, r_f3, r_a, r_wd);
            check_op($sformatf("rnd%0d", n), e, cyc, exp_rd, !e && r_we,
                     (r_f3 == 3'b011) ? 1 : 3, {r_a[63:3], 3'b000}, ref_dword(r_a));
            check64($sformatf("rnd%0d.mem", n), dmem[r_a[9:3]], ref_dword(r_a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
